wt_dcache_rrip: RTL and testbench



---
 rtl/wt_cache_pkg.sv | 26 ++
 rtl/wt_dcache_rrip_victim.sv | 53 +++++
 rtl/wt_dcache_rrip.sv | 149 ++++++++++++++
 tb/tb_wt_dcache_rrip.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through dcache RRIP replacement engine.
package wt_cache_pkg;

    localparam int DCACHE_NUM_WORDS   = 256;
    localparam int DCACHE_SET_ASSOC   = 4;
    localparam int RRPV_BITS_DEFAULT  = 2;

    typedef enum logic [1:0] {
        RRIP_SRRIP = 2'd0,
        RRIP_BRRIP = 2'd1,
        RRIP_DRRIP = 2'd2
    } rrip_mode_e;

    // Long re-reference (RMAX-1) unless BRRIP picks the distant value RMAX.
    function automatic int rrip_insert_val(input logic use_brrip,
                                           input logic brrip_long,
                                           input int   rrpv_bits);
        int rmax;
        rmax = (1 << rrpv_bits) - 1;
        if (use_brrip && !brrip_long) begin
            return rmax;
        end
        return rmax - 1;
    endfunction

endpackage

// File: rtl/wt_dcache_rrip_victim.sv
// Per-set victim pick (invalid first, else lowest way at max RRPV) and aged RRPV vector.
module wt_dcache_rrip_victim #(
    parameter int NUM_WAYS  = 4,
    parameter int RRPV_BITS = 2
) (
    input  logic [NUM_WAYS-1:0][RRPV_BITS-1:0] i_rrpv,
    input  logic [NUM_WAYS-1:0]                i_valid,
    output logic [$clog2(NUM_WAYS)-1:0]        o_victim,
    output logic [NUM_WAYS-1:0][RRPV_BITS-1:0] o_aged
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam logic [RRPV_BITS-1:0] RMAX = '1;

    logic [RRPV_BITS-1:0] w_maxv;
    logic [RRPV_BITS-1:0] w_delta;
    logic [WAY_BITS-1:0]  w_inv_way;
    logic [WAY_BITS-1:0]  w_max_way;
    logic                 w_any_inv;

    always_comb begin
        w_maxv    = '0;
        w_inv_way = '0;
        w_max_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_rrpv[i] > w_maxv) begin
                w_maxv = i_rrpv[i];
            end
        end
        // Scan downwards so the final match is the lowest index.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                w_inv_way = WAY_BITS'(i);
            end
            if (i_rrpv[i] == w_maxv) begin
                w_max_way = WAY_BITS'(i);
            end
        end
    end

    assign w_any_inv = ~&i_valid;
    assign o_victim  = w_any_inv ? w_inv_way : w_max_way;
    // Zero when some way already sits at RMAX, so no separate guard is needed.
    assign w_delta   = RMAX - w_maxv;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_age
            assign o_aged[gi] = i_rrpv[gi] + w_delta;
        end
    endgenerate

endmodule

// File: rtl/wt_dcache_rrip.sv
// RRIP replacement engine (SRRIP / BRRIP / DRRIP set dueling) with a sequential flush walk.
module wt_dcache_rrip
    import wt_cache_pkg::*;
#(
    parameter int NUM_SETS    = DCACHE_NUM_WORDS,
    parameter int NUM_WAYS    = DCACHE_SET_ASSOC,
    parameter int RRPV_BITS   = RRPV_BITS_DEFAULT,
    parameter int PSEL_BITS   = 10,
    parameter int DUEL_STRIDE = 32,
    parameter int BRRIP_EPS   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    output logic                        busy_o,
    input  logic [1:0]                  mode_i,
    input  logic                        hit_i,
    input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
    input  logic [$clog2(NUM_WAYS)-1:0] hit_way_i,
    input  logic                        miss_i,
    input  logic [$clog2(NUM_SETS)-1:0] miss_idx_i,
    input  logic [NUM_WAYS-1:0]         valid_mask_i,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way_o,
    output logic [PSEL_BITS-1:0]        psel_o
);

    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int BCNT_BITS = $clog2(BRRIP_EPS);

    typedef logic [NUM_WAYS-1:0][RRPV_BITS-1:0] set_t;
    typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

    set_t                 r_rrpv [NUM_SETS];
    state_e               r_state;
    logic                 r_busy;
    logic [IDX_BITS-1:0]  r_flush_ptr;
    logic [PSEL_BITS-1:0] r_psel;
    logic [BCNT_BITS-1:0] r_brrip_cnt;

    set_t                 w_miss_set;
    set_t                 w_aged;
    set_t                 w_new_set;
    logic [WAY_BITS-1:0]  w_victim;
    logic [31:0]          w_idx_mod;
    logic                 w_srrip_leader;
    logic                 w_brrip_leader;
    logic                 w_is_drrip;
    logic                 w_use_brrip;
    logic [RRPV_BITS-1:0] w_ins;

    assign w_miss_set = r_rrpv[miss_idx_i];

    wt_dcache_rrip_victim #(
        .NUM_WAYS  (NUM_WAYS),
        .RRPV_BITS (RRPV_BITS)
    ) u_victim (
        .i_rrpv   (w_miss_set),
        .i_valid  (valid_mask_i),
        .o_victim (w_victim),
        .o_aged   (w_aged)
    );

    assign w_idx_mod      = 32'(miss_idx_i) & 32'(DUEL_STRIDE - 1);
    assign w_srrip_leader = (w_idx_mod == 32'd0);
    assign w_brrip_leader = (w_idx_mod == 32'(DUEL_STRIDE - 1));
    assign w_is_drrip     = (mode_i == RRIP_DRRIP);

    // Leader sets override the PSEL vote; mode 3 falls through to SRRIP.
    always_comb begin
        w_use_brrip = 1'b0;
        if (mode_i == RRIP_BRRIP) begin
            w_use_brrip = 1'b1;
        end else if (w_is_drrip) begin
            if (w_srrip_leader) begin
                w_use_brrip = 1'b0;
            end else if (w_brrip_leader) begin
                w_use_brrip = 1'b1;
            end else begin
                w_use_brrip = r_psel[PSEL_BITS-1];
            end
        end
    end

    assign w_ins = RRPV_BITS'(rrip_insert_val(w_use_brrip, r_brrip_cnt == '0, RRPV_BITS));

    // Aged set, then a same-set hit, then the insertion (so the miss wins on a way clash).
    always_comb begin
        w_new_set = w_aged;
        if (hit_i && (hit_idx_i == miss_idx_i)) begin
            w_new_set[hit_way_i] = '0;
        end
        w_new_set[w_victim] = w_ins;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_rrpv[s] <= '1;
            end
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_flush_ptr <= '0;
            r_psel      <= {1'b1, {(PSEL_BITS-1){1'b0}}};
            r_brrip_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush_i) begin
                        r_state     <= ST_FLUSH;
                        r_busy      <= 1'b1;
                        r_flush_ptr <= '0;
                    end
                    if (hit_i) begin
                        r_rrpv[hit_idx_i][hit_way_i] <= '0;
                    end
                    if (miss_i) begin
                        r_rrpv[miss_idx_i] <= w_new_set;
                        if (w_use_brrip) begin
                            r_brrip_cnt <= r_brrip_cnt + BCNT_BITS'(1);
                        end
                        if (w_is_drrip && w_srrip_leader && (r_psel != '1)) begin
                            r_psel <= r_psel + PSEL_BITS'(1);
                        end else if (w_is_drrip && w_brrip_leader && (r_psel != '0)) begin
                            r_psel <= r_psel - PSEL_BITS'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    r_rrpv[r_flush_ptr] <= '1;
                    r_flush_ptr         <= r_flush_ptr + IDX_BITS'(1);
                    if (r_flush_ptr == IDX_BITS'(NUM_SETS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign victim_way_o = r_busy ? '0 : w_victim;
    assign psel_o       = r_psel;

endmodule

// File: tb/tb_wt_dcache_rrip.sv
// Scoreboard bench: driver pushes model expectations, a negedge monitor pops and compares.
module tb_wt_dcache_rrip;

    localparam int NS   = 256;
    localparam int NW   = 4;
    localparam int RB   = 2;
    localparam int PB   = 10;
    localparam int DS   = 32;
    localparam int EPS  = 32;
    localparam int RMAX = (1 << RB) - 1;
    localparam int PMAX = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          busy_o;
    logic [1:0]    mode_i = '0;
    logic          hit_i = 1'b0;
    logic [7:0]    hit_idx_i = '0;
    logic [1:0]    hit_way_i = '0;
    logic          miss_i = 1'b0;
    logic [7:0]    miss_idx_i = '0;
    logic [NW-1:0] valid_mask_i = '1;
    logic [1:0]    victim_way_o;
    logic [PB-1:0] psel_o;

    always #5 clk = ~clk;

    wt_dcache_rrip #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .RRPV_BITS(RB),
        .PSEL_BITS(PB), .DUEL_STRIDE(DS), .BRRIP_EPS(EPS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .mode_i       (mode_i),
        .hit_i        (hit_i),
        .hit_idx_i    (hit_idx_i),
        .hit_way_i    (hit_way_i),
        .miss_i       (miss_i),
        .miss_idx_i   (miss_idx_i),
        .valid_mask_i (valid_mask_i),
        .victim_way_o (victim_way_o),
        .psel_o       (psel_o)
    );

    typedef struct {
        int cyc;
        int kind;   // 0 victim, 1 psel, 2 busy
        int val;
    } exp_t;

    exp_t q_exp[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    // Reference state
    int m_rrpv [NS][NW];
    int m_psel;
    int m_bcnt;
    bit m_busy;
    int m_ptr;

    always @(posedge clk) cyc++;

    function automatic int m_victim(input int idx, input logic [NW-1:0] mask);
        int mx;
        for (int w = 0; w < NW; w++) if (!mask[w]) return w;
        mx = 0;
        for (int w = 0; w < NW; w++) if (m_rrpv[idx][w] > mx) mx = m_rrpv[idx][w];
        for (int w = 0; w < NW; w++) if (m_rrpv[idx][w] == mx) return w;
        return 0;
    endfunction

    function automatic bit m_has_rmax(input int idx);
        for (int w = 0; w < NW; w++) if (m_rrpv[idx][w] == RMAX) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int  v, ins, mi, hi;
        bit  brrip;
        mi = int'(miss_idx_i);
        hi = int'(hit_idx_i);
        if (!rst_i) q_exp.push_back('{cyc, 0, m_busy ? 0 : m_victim(mi, valid_mask_i)});
        if (rst_i) begin
            for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) m_rrpv[s][w] = RMAX;
            m_psel = 1 << (PB - 1);
            m_bcnt = 0;
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            for (int w = 0; w < NW; w++) m_rrpv[m_ptr][w] = RMAX;
            m_ptr++;
            if (m_ptr == NS) m_busy = 1'b0;
        end else begin
            if (flush_i) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
            v = 0; ins = 0;
            if (miss_i) begin
                v = m_victim(mi, valid_mask_i);
                brrip = 1'b0;
                if (mode_i == 2'd1) brrip = 1'b1;
                else if (mode_i == 2'd2) begin
                    if (mi % DS == 0) begin
                        brrip = 1'b0;
                        if (m_psel < PMAX) m_psel++;
                    end else if (mi % DS == DS - 1) begin
                        brrip = 1'b1;
                        if (m_psel > 0) m_psel--;
                    end else begin
                        brrip = (m_psel >= (1 << (PB - 1)));
                    end
                end
                ins = RMAX - 1;
                if (brrip) begin
                    if (m_bcnt != 0) ins = RMAX;
                    m_bcnt = (m_bcnt + 1) % EPS;
                end
                // Aging as repeated increments until some way reaches RMAX.
                while (!m_has_rmax(mi)) for (int w = 0; w < NW; w++) m_rrpv[mi][w]++;
            end
            if (hit_i) m_rrpv[hi][hit_way_i] = 0;
            if (miss_i) m_rrpv[mi][v] = ins;
        end
        q_exp.push_back('{cyc + 1, 1, m_psel});
        q_exp.push_back('{cyc + 1, 2, int'(m_busy)});
    endtask

    task automatic step(input bit r, input bit f, input int md, input bit h, input int hi,
                        input int hw, input bit m, input int mi, input logic [NW-1:0] mk);
        @(posedge clk);
        #1;
        rst_i        = r;
        flush_i      = f;
        mode_i       = 2'(md);
        hit_i        = h;
        hit_idx_i    = 8'(hi);
        hit_way_i    = 2'(hw);
        miss_i       = m;
        miss_idx_i   = 8'(mi);
        valid_mask_i = mk;
        model_step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (q_exp.size() > 0 && q_exp[0].cyc <= cyc) begin
            e = q_exp.pop_front();
            case (e.kind)
                0:       act = int'(victim_way_o);
                1:       act = int'(psel_o);
                default: act = int'(busy_o);
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s cyc=%0d got %0d expected %0d",
                         (e.kind == 0) ? "victim" : (e.kind == 1) ? "psel" : "busy",
                         cyc, act, e.val);
            end
        end
    end

    function automatic int pick_idx();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 31;
            2:       return 32;
            3:       return 63;
            4:       return 5;
            5:       return 7;
            default: return int'($urandom_range(0, NS - 1));
        endcase
    endfunction

    initial begin
        int mi, hi, r;
        logic [NW-1:0] mk;

        step(1, 0, 0, 0, 0, 0, 0, 0, '1);
        step(0, 0, 0, 0, 0, 0, 0, 0, '1);
        // Cold set 5: victim 0 then victim 1
        step(0, 0, 0, 0, 0, 0, 1, 5, '1);
        step(0, 0, 0, 0, 0, 0, 1, 5, '1);
        // Invalid way 2 wins over RRPV, with a same-set hit on way 1
        step(0, 0, 0, 1, 3, 1, 1, 3, 4'b1011);
        step(0, 0, 0, 0, 0, 0, 1, 3, '1);

        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 999));
            mi = pick_idx();
            hi = ($urandom_range(0, 2) == 0) ? mi : pick_idx();
            mk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step(r < 3, (r >= 3) && (r < 8), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), hi, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), mi, mk);
        end

        // Let any walk finish, then a BRRIP burst on one set
        for (int i = 0; i < NS + 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, '1);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0, 0, 1, 10, '1);

        // DRRIP: SRRIP leader drives psel to saturation, then BRRIP leader to zero
        for (int i = 0; i < 600; i++) step(0, 0, 2, 0, 0, 0, 1, 0, '1);
        for (int i = 0; i < 8; i++)   step(0, 0, 2, 0, 0, 0, 1, 40, '1);
        for (int i = 0; i < 1100; i++) step(0, 0, 2, 0, 0, 0, 1, 31, '1);
        for (int i = 0; i < 8; i++)   step(0, 0, 2, 0, 0, 0, 1, 40, '1);

        // Full flush walk with ignored misses/hits, then misses see all-RMAX sets
        step(0, 1, 0, 0, 0, 0, 0, 0, '1);
        for (int i = 0; i < NS + 2; i++)
            step(0, i == 10, 0, 1, pick_idx(), 0, 1, pick_idx(), '1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, pick_idx(), '1);

        // Reset in the middle of a walk
        step(0, 1, 0, 0, 0, 0, 0, 0, '1);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 0, 1, 9, '1);
        step(1, 0, 0, 0, 0, 0, 1, 9, '1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 9, '1);

        step(0, 0, 0, 0, 0, 0, 0, 0, '1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
